sha256_mem_hasher: RTL
======================

// Module: sha256_mem_hasher
// PURPOSE
//  Memory-mapped SHA-256 engine for runtime-variable message length (whole 32-bit words, big-endian).
//  Reads message from word memory, pads on the fly (no message buffer), hashes B blocks, writes 8-word digest.
//  Successor of the fixed-length hasher: runtime length, generic padding, pipelined reads, error reporting.
// PARAMETERS
//  ADDR_W     16    memory word-address width
//  MAX_WORDS  1024  largest accepted num_words; NW_W = $clog2(MAX_WORDS+1)
// PORTS
//  clk             in   1       single clock, rising edge; also drives mem_clk
//  reset           in   1       asynchronous, active-high reset
//  start           in   1       sampled in IDLE only; begins a hash
//  num_words       in   NW_W    message length L in words, 0..MAX_WORDS; sampled with start
//  message_addr    in   ADDR_W  first message word address; sampled with start
//  output_addr     in   ADDR_W  first digest word address; sampled with start
//  done            out  1       high in IDLE
//  error           out  1       sticky: last start had L>MAX_WORDS; cleared by next accepted start
//  mem_clk         out  1       = clk
//  mem_we          out  1       write strobe
//  mem_addr        out  ADDR_W  word address
//  mem_write_data  out  32      digest word
//  mem_read_data   in   32      sync RAM: data for mem_addr driven in cycle N is valid in cycle N+1
// BEHAVIOUR
//  Reset: state=IDLE, done=1, error=0, mem_we=0, mem_addr=0, mem_write_data=0.
//  Blocks B = floor((L+18)/16). Padded word j: j<L mem[message_addr+j]; j==L 32'h80000000;
//   j==16B-2 upper 32 bits of L*32; j==16B-1 lower 32 bits of L*32; all others 0.
//  FSM: IDLE -> LOAD -> COMPUTE -> UPDATE -> (LOAD | WRITE) -> IDLE.
//   IDLE: on start with L<=MAX_WORDS: H,a..h <= IV, blk=0, error<=0 -> LOAD.
//    L>MAX_WORDS: error<=1, no memory access, stay IDLE. start ignored outside IDLE.
//   LOAD: 17 cycles; cycles 0..15 issue addr for word 16*blk+k (pad words need no read; mem_addr holds
//    last valid address, no side effect); captured data/pad shifts into w[0..15].
//   COMPUTE: 64 cycles, one round per cycle, w schedule w16=s1(w14)+w9+s0(w1)+w0 shifts in.
//   UPDATE: 1 cycle; H[i]<=H[i]+var[i], a..h<=new H; blk++; blk==B -> WRITE else LOAD.
//   WRITE: 8 cycles; mem_we=1, mem_addr=output_addr+i, mem_write_data=H[i], i=0..7; then IDLE.
//  Latency: done low for exactly 82*B+8 cycles after start accepted; L=0 gives B=1.
//  Arithmetic: all adds mod 2^32; address adds mod 2^ADDR_W (wrap, no error).
//  Reset mid-operation: immediate IDLE, mem_we=0 same cycle; partial digest never written.
//  mem_we never asserted outside WRITE; no memory reads in IDLE/COMPUTE/UPDATE/WRITE.
// CONFIGURATION
//  SHA256_SHA224_MODE_EN defined: adds input port sha224 (1, sampled with start); when 1 use SHA-224 IV,
//   WRITE lasts 7 cycles (H0..H6), done low 82*B+7 cycles. Undefined: port absent, SHA-256 only.
// STRUCTURE
//  sha256_pkg: K[0:63], IV256[8], IV224[8], state enum, functions rotr, sigma0/1, Sigma0/1, ch, maj.
//  Sub-module sha256_msg_sched: 16x32 w shift register, load-shift in LOAD, expand-shift in COMPUTE,
//   outputs w[0] for current round.
//  Top holds FSM, padding mux, round datapath, H registers, write sequencer.
// TESTING
//  L=0 -> one block, 0 mem reads, digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  L=1, mem=32'h61626364 ("abcd") -> 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
//  L=13 vs L=14 -> B=1 (90 cycles) vs B=2 (172 cycles); digests match C model; read count =L exactly.
//  L=20 at message_addr=16'hFFF8 -> addresses wrap to 0; digest matches model; 8 writes at output_addr.
//  L=MAX_WORDS+1 -> error=1, done stays 1, zero mem accesses; next valid start clears error.
//  reset pulse in COMPUTE of block 2 -> IDLE, mem_we=0, no writes; fresh L=0 start yields correct digest.
//  [SHA256_SHA224_MODE_EN] sha224=1, L=0 -> 7 writes: d14a028c 2a3a2bc9 476102bb 288234c4 15a2b01f 828ea62a c5b3e42f.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the bitwise round/schedule helper functions.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_UPDATE,
        S_WRITE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule window: loads padded words during LOAD, expands W[16..63] during COMPUTE.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        expand_en,
    input  logic [31:0] load_word,
    output logic [31:0] w0
);

    logic [15:0][31:0] w_reg;
    logic [15:0][31:0] w_next;
    logic [31:0]       w_new;

    assign w_new = load_en ? load_word
                           : sigma1(w_reg[14]) + w_reg[9] + sigma0(w_reg[1]) + w_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            if (gi < 15) begin : g_mid
                assign w_next[gi] = w_reg[gi+1];
            end else begin : g_top
                assign w_next[gi] = w_new;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_reg <= '0;
        end else if (load_en || expand_en) begin
            w_reg <= w_next;
        end
    end

    assign w0 = w_reg[0];

endmodule

// File: rtl/sha256_mem_hasher.sv
// Memory-mapped SHA-256 engine with on-the-fly padding of a runtime-length word message.
// Define SHA256_SHA224_MODE_EN to add the sha224 input (SHA-224 IV, 7-word digest).
module sha256_mem_hasher
    import sha256_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 1024,
    localparam int NW_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef SHA256_SHA224_MODE_EN
    input  logic              sha224,
`endif
    input  logic [NW_W-1:0]   num_words,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    output logic              done,
    output logic              error,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int IDX_W = NW_W + 4;
    localparam logic [NW_W-1:0] MAX_NW = NW_W'(MAX_WORDS);

    state_t            state_reg, state_next;
    logic [6:0]        cnt_reg;
    logic [NW_W-1:0]   blk_reg, nblk_reg, len_reg;
    logic [NW_W:0]     nblk_sum;
    logic [ADDR_W-1:0] maddr_reg, oaddr_reg, addr_reg;
    logic [IDX_W-1:0]  issue_idx, cap_idx_reg, last_idx;
    logic              issue_rd, rd_pend_reg, error_reg;
    logic              load_en, expand_en;
    logic [31:0]       h_reg [0:7];
    logic [31:0]       v_reg [0:7];
    logic [31:0]       iv [0:7];
    logic [31:0]       pad_word, load_word, w0, t1, t2;
    logic [63:0]       len_bits;
    logic [2:0]        last_wr;

`ifdef SHA256_SHA224_MODE_EN
    logic mode224_reg;
    always_comb begin
        last_wr = mode224_reg ? 3'd6 : 3'd7;
        for (int i = 0; i < 8; i++) iv[i] = sha224 ? IV224[i] : IV256[i];
    end
`else
    always_comb begin
        last_wr = 3'd7;
        for (int i = 0; i < 8; i++) iv[i] = IV256[i];
    end
`endif

    // Word index issued this cycle; its data (or pad) is captured one cycle later.
    assign issue_idx = {blk_reg, 4'b0000} + IDX_W'(cnt_reg[3:0]);
    assign issue_rd  = (state_reg == S_LOAD) && (cnt_reg < 7'd16) && (issue_idx < IDX_W'(len_reg));
    assign last_idx  = {nblk_reg, 4'b0000} - IDX_W'(1);
    assign len_bits  = 64'(len_reg) << 5;
    assign nblk_sum  = (NW_W+1)'(num_words) + (NW_W+1)'(18);

    always_comb begin
        pad_word = 32'h0;
        if (cap_idx_reg == IDX_W'(len_reg))       pad_word = 32'h8000_0000;
        else if (cap_idx_reg == last_idx - 1'b1)  pad_word = len_bits[63:32];
        else if (cap_idx_reg == last_idx)         pad_word = len_bits[31:0];
    end

    assign load_word = rd_pend_reg ? mem_read_data : pad_word;

    sha256_msg_sched u_sched (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .expand_en (expand_en),
        .load_word (load_word),
        .w0        (w0)
    );

    assign t1 = v_reg[7] + big_sigma1(v_reg[4]) + ch(v_reg[4], v_reg[5], v_reg[6]) + K[cnt_reg[5:0]] + w0;
    assign t2 = big_sigma0(v_reg[0]) + maj(v_reg[0], v_reg[1], v_reg[2]);

    always_comb begin
        state_next     = state_reg;
        load_en        = 1'b0;
        expand_en      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = addr_reg;
        mem_write_data = 32'h0;
        case (state_reg)
            S_IDLE: begin
                if (start && num_words <= MAX_NW) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (issue_rd) mem_addr = maddr_reg + ADDR_W'(issue_idx);
                load_en = (cnt_reg != 7'd0);
                if (cnt_reg == 7'd16) state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                expand_en = 1'b1;
                if (cnt_reg == 7'd63) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                state_next = (blk_reg + NW_W'(1) == nblk_reg) ? S_WRITE : S_LOAD;
            end
            S_WRITE: begin
                mem_we         = 1'b1;
                mem_addr       = oaddr_reg + ADDR_W'(cnt_reg[2:0]);
                mem_write_data = h_reg[cnt_reg[2:0]];
                if (cnt_reg[2:0] == last_wr) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            blk_reg     <= '0;
            nblk_reg    <= '0;
            len_reg     <= '0;
            maddr_reg   <= '0;
            oaddr_reg   <= '0;
            addr_reg    <= '0;
            cap_idx_reg <= '0;
            rd_pend_reg <= 1'b0;
            error_reg   <= 1'b0;
`ifdef SHA256_SHA224_MODE_EN
            mode224_reg <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= '0;
                v_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            addr_reg    <= mem_addr;
            cap_idx_reg <= issue_idx;
            rd_pend_reg <= issue_rd;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (num_words > MAX_NW) begin
                            error_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b0;
                            len_reg   <= num_words;
                            maddr_reg <= message_addr;
                            oaddr_reg <= output_addr;
                            nblk_reg  <= NW_W'(nblk_sum >> 4);
                            blk_reg   <= '0;
                            cnt_reg   <= '0;
`ifdef SHA256_SHA224_MODE_EN
                            mode224_reg <= sha224;
`endif
                            for (int i = 0; i < 8; i++) begin
                                h_reg[i] <= iv[i];
                                v_reg[i] <= iv[i];
                            end
                        end
                    end
                end
                S_LOAD:    cnt_reg <= (cnt_reg == 7'd16) ? 7'd0 : cnt_reg + 7'd1;
                S_COMPUTE: begin
                    cnt_reg  <= (cnt_reg == 7'd63) ? 7'd0 : cnt_reg + 7'd1;
                    v_reg[0] <= t1 + t2;
                    v_reg[1] <= v_reg[0];
                    v_reg[2] <= v_reg[1];
                    v_reg[3] <= v_reg[2];
                    v_reg[4] <= v_reg[3] + t1;
                    v_reg[5] <= v_reg[4];
                    v_reg[6] <= v_reg[5];
                    v_reg[7] <= v_reg[6];
                end
                S_UPDATE: begin
                    cnt_reg <= '0;
                    blk_reg <= blk_reg + NW_W'(1);
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i] <= h_reg[i] + v_reg[i];
                        v_reg[i] <= h_reg[i] + v_reg[i];
                    end
                end
                S_WRITE:   cnt_reg <= cnt_reg + 7'd1;
                default:   cnt_reg <= '0;
            endcase
        end
    end

    assign done    = (state_reg == S_IDLE);
    assign error   = error_reg;
    assign mem_clk = clk;

endmodule
